// File: rtl/cvxif_instr_pkg.sv
// Shared types for the CV-X-IF example coprocessor: decoded opcodes, the BCD
// execution FSM states and a one-digit BCD adder used by the execution unit.
package cvxif_instr_pkg;

  typedef enum logic [1:0] {
    ILLEGAL    = 2'd0,
    BCDfromBIN = 2'd1,
    BCDADD     = 2'd2
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    ADD  = 2'd2,
    RESP = 2'd3
  } bcd_exec_state_t;

  typedef struct packed {
    logic       carry;
    logic [3:0] digit;
  } bcd_digit_t;

  // Decimal-adjusted digit add; non-BCD digits go through the same +6 rule.
  function automatic bcd_digit_t bcd_add_digit(input logic [3:0] a,
                                               input logic [3:0] b,
                                               input logic       cin);
    bcd_digit_t res;
    logic [4:0] sum;
    logic [4:0] fixed;
    sum       = {1'b0, a} + {1'b0, b} + {4'b0, cin};
    fixed     = sum + 5'd6;
    res.carry = (sum > 5'd9);
    res.digit = res.carry ? fixed[3:0] : sum[3:0];
    return res;
  endfunction

endpackage

// File: rtl/cvxif_bcd_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 so that the
// following left shift carries into the next decimal digit.
module cvxif_bcd_digit_adj (
  input  logic [3:0] digit,
  output logic [3:0] adj
);

  assign adj = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/cvxif_bcd_exec.sv
// Iterative BCD execution back end: holds one decoded instruction, converts
// binary to BCD (one bit per cycle) or adds BCD (one digit per cycle).
module cvxif_bcd_exec
  import cvxif_instr_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned IdWidth = 3
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  opcode_t            req_opcode_i,
  input  logic [IdWidth-1:0] req_id_i,
  input  logic [4:0]         req_rd_i,
  input  logic [XLEN-1:0]    req_rs1_i,
  input  logic [XLEN-1:0]    req_rs2_i,
  output logic               result_valid_o,
  input  logic               result_ready_i,
  output logic [IdWidth-1:0] result_id_o,
  output logic [4:0]         result_rd_o,
  output logic               result_we_o,
  output logic [XLEN-1:0]    result_data_o
);

  localparam int unsigned NumDigits = XLEN / 4;
  localparam int unsigned CntWidth  = $clog2(XLEN) + 1;
  localparam logic [CntWidth-1:0] ConvLast = CntWidth'(XLEN - 1);
  localparam logic [CntWidth-1:0] AddLast  = CntWidth'(NumDigits - 1);

  bcd_exec_state_t     state;
  logic [CntWidth-1:0] cnt;
  logic [XLEN-1:0]     acc;
  logic [XLEN-1:0]     acc_adj;
  logic [XLEN-1:0]     op_a;
  logic [XLEN-1:0]     op_b;
  logic                carry;
  logic [IdWidth-1:0]  id_q;
  logic [4:0]          rd_q;
  logic                we_q;
  logic                valid_q;
  bcd_digit_t          add_res;

  for (genvar g = 0; g < NumDigits; g++) begin : g_adj
    cvxif_bcd_digit_adj u_adj (
      .digit (acc[4*g +: 4]),
      .adj   (acc_adj[4*g +: 4])
    );
  end

  // The adder always looks at the low digit; operands shift right each cycle.
  assign add_res     = bcd_add_digit(op_a[3:0], op_b[3:0], carry);
  assign req_ready_o = (state == IDLE) && !flush_i;

  // NOTE: every register here, the datapath included, takes the async reset so
  // outputs read zero straight out of reset; state updates use <= so all
  // registers sample the same pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      op_a    <= '0;
      op_b    <= '0;
      carry   <= 1'b0;
      id_q    <= '0;
      rd_q    <= '0;
      we_q    <= 1'b0;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      state   <= IDLE;
      valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            id_q  <= req_id_i;
            rd_q  <= req_rd_i;
            op_a  <= req_rs1_i;
            op_b  <= req_rs2_i;
            cnt   <= '0;
            acc   <= '0;
            carry <= 1'b0;
            case (req_opcode_i)
              BCDfromBIN: begin
                state <= CONV;
                we_q  <= 1'b1;
              end
              BCDADD: begin
                state <= ADD;
                we_q  <= 1'b1;
              end
              default: begin
                state   <= RESP;
                we_q    <= 1'b0;
                valid_q <= 1'b1;
              end
            endcase
          end
        end
        CONV: begin
          // Adjust first, then shift in the next binary bit, MSB first.
          acc  <= {acc_adj[XLEN-2:0], op_a[XLEN-1]};
          op_a <= {op_a[XLEN-2:0], 1'b0};
          cnt  <= cnt + CntWidth'(1);
          if (cnt == ConvLast) begin
            state   <= RESP;
            valid_q <= 1'b1;
          end
        end
        ADD: begin
          // Sum digits enter at the top; after all digits the LSB lands at bit 0.
          acc   <= {add_res.digit, acc[XLEN-1:4]};
          op_a  <= {4'b0, op_a[XLEN-1:4]};
          op_b  <= {4'b0, op_b[XLEN-1:4]};
          carry <= add_res.carry;
          cnt   <= cnt + CntWidth'(1);
          if (cnt == AddLast) begin
            state   <= RESP;
            valid_q <= 1'b1;
          end
        end
        RESP: begin
          if (result_ready_i) begin
            state   <= IDLE;
            valid_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign result_valid_o = valid_q;
  assign result_id_o    = id_q;
  assign result_rd_o    = rd_q;
  assign result_we_o    = we_q;
  assign result_data_o  = acc;

endmodule

// File: doc/cvxif_bcd_exec.md
# cvxif_bcd_exec

Execution back end of the CV-X-IF example coprocessor. It receives instructions that the coprocessor's issue decoder has already accepted, carrying a decoded `opcode_t`, an instruction id, rd and operand values. It computes the BCD result iteratively and returns it to the core over a valid/ready result handshake. It sits between the issue-decode stage and the X-interface result channel, and holds exactly one instruction at a time.

## Interface
Parameters:
- `XLEN`, default 32: operand/result width; must be a multiple of 4 (XLEN/4 BCD digits).
- `IdWidth`, default 3: width of the instruction id.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `flush_i` in 1: abort any in-flight instruction.
- `req_valid_i` in 1: decoded instruction present.
- `req_ready_o` out 1: block can accept an instruction.
- `req_opcode_i` in `opcode_t`: ILLEGAL / BCDfromBIN / BCDADD.
- `req_id_i` in IdWidth: instruction id.
- `req_rd_i` in 5: destination register.
- `req_rs1_i` in XLEN: operand 1.
- `req_rs2_i` in XLEN: operand 2 (BCDADD only).
- `result_valid_o` out 1: result present.
- `result_ready_i` in 1: core takes result.
- `result_id_o` out IdWidth: id of the completing instruction.
- `result_rd_o` out 5: destination register.
- `result_we_o` out 1: write rd (0 for ILLEGAL).
- `result_data_o` out XLEN: BCD result.

## Operation
- FSM states: IDLE, CONV, ADD, RESP.
- `req_ready_o` = (state == IDLE) and not `flush_i`.
- Accept: `req_valid_i & req_ready_o` at a clock edge.
  - On accept, register id, rd and operands, and clear the counter and accumulator.
  - BCDfromBIN goes to CONV, BCDADD goes to ADD, ILLEGAL goes directly to RESP with data 0 and we 0.
- CONV (double dabble), one bin bit per cycle, MSB first:
  - Add 3 to every accumulator digit ≥5.
  - Shift the accumulator left 1, inserting the next rs1 bit.
  - After XLEN cycles, go to RESP.
  - The accumulator is XLEN bits wide; carry out of the top digit is discarded, so the result is rs1 mod 10^(XLEN/4), in BCD.
- ADD: one digit per cycle, LSB digit first, with a carry flag.
  - s = a + b + c.
  - If s > 9: digit = (s+6)[3:0] and c = 1; otherwise digit = s and c = 0.
  - After XLEN/4 cycles, go to RESP. The final carry is discarded (wrap mod 10^(XLEN/4)).
  - Non-BCD input digits are processed by the same rule; no error is signalled.
- RESP: `result_valid_o` = 1, with all result outputs stable.
  - On `result_ready_i`, go to IDLE.
  - The result outputs do not change while valid is high and ready is low.
- `flush_i` in any state: go to IDLE at the next edge and drop the result. A flush in the same cycle as `req_valid_i` suppresses acceptance.
- Reset: state IDLE, counter 0, accumulator 0. All outputs then read 0 except `req_ready_o`, which reads 1 once `rst_ni` deasserts.

## Timing
- Accept edge is E0.
  - BCDfromBIN: `result_valid_o` is high in the cycle after edge E0+XLEN (32 for the default).
  - BCDADD: high after edge E0+XLEN/4 (8 for the default).
  - ILLEGAL: high after edge E0.
- Result transfers at the first edge where valid & ready are both high. `req_ready_o` rises in the following cycle, so there is no back-to-back accept in the same cycle as the result transfer. The minimum issue interval is latency+2 cycles.
- `req_ready_o` and `result_valid_o` are never high in the same cycle.
- Reset asserted mid-operation clears everything immediately (asynchronous). No result is emitted for the interrupted instruction.

## Structure
- Uses `opcode_t` from `cvxif_instr_pkg`.
- Add `bcd_exec_state_t` (IDLE/CONV/ADD/RESP) to the same package.
- Sub-module `cvxif_bcd_digit_adj`: combinational per-digit "+3 if ≥5" correction, instantiated XLEN/4 times in a generate loop.
- Counter width is $clog2(XLEN)+1.

## Test plan
- BCDfromBIN, rs1=0x000000FF, id 2, rd 5 -> after 32 cycles: data 0x00000255, id 2, rd 5, we 1.
- BCDfromBIN, rs1=0x00BC614E -> 0x12345678. Overflow case: rs1=0xFFFFFFFF -> 0x94967295.
- BCDADD, 0x00000999 + 0x00000001 -> 0x00001000 after 8 cycles. Wrap case: 0x99999999 + 0x00000001 -> 0x00000000.
- Backpressure: hold `result_ready_i` low for 5 cycles in RESP -> valid stays high, outputs unchanged, `req_ready_o` stays 0. Result transfers on the first ready edge; `req_ready_o` is 1 in the next cycle.
- `flush_i` pulse at cycle 10 of CONV -> no result, IDLE next cycle. A new BCDADD 0x00000005 + 0x00000005 then returns 0x00000010.
- ILLEGAL opcode, id 7 -> result one cycle after accept with we 0, data 0, id 7. Reset mid-ADD -> all outputs 0 and `req_ready_o` 1 after release.
